// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, data width and transmit FSM states.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with a show-ahead read port and registered full/empty flags.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic                 do_wr, do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_comb begin
    wr_ptr_n = wr_ptr + {{AW{1'b0}}, do_wr};
    rd_ptr_n = rd_ptr + {{AW{1'b0}}, do_rd};
  end

  // Flags are computed from the next pointers so they change on the same edge as the level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
      empty  <= (wr_ptr_n == rd_ptr_n);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: FIFO-fed 8-bit frames with optional per-frame parity and one stop bit.
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 7,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] d_in,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic       tx,
  output logic       tx_full,
  output logic       tx_busy
);

  localparam int unsigned     BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            state, state_n;
  logic [BW-1:0]        baud_cnt, baud_n;
  logic [2:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_en_q, par_en_n;
  logic                 par_bit_q, par_bit_n;
  logic                 tx_n, pop, baud_last;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_empty;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_en),
    .din   (d_in),
    .rd_en (pop),
    .dout  (fifo_dout),
    .full  (tx_full),
    .empty (fifo_empty)
  );

  assign baud_last = (baud_cnt == BAUD_MAX);

  always_comb begin
    state_n   = state;
    baud_n    = baud_last ? '0 : baud_cnt + 1'b1;
    bit_n     = bit_cnt;
    shift_n   = shift;
    par_en_n  = par_en_q;
    par_bit_n = par_bit_q;
    pop       = 1'b0;
    tx_n      = STOP_BIT;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx_n = START_BIT;
        if (baud_last) state_n = DATA;
      end
      DATA: begin
        tx_n = shift[0];
        if (baud_last) begin
          shift_n = shift >> 1;
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) state_n = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx_n = par_bit_q;
        if (baud_last) state_n = STOP;
      end
      STOP: begin
        tx_n = STOP_BIT;
        if (baud_last) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Parity is resolved at load time since the shift register is consumed during DATA.
    if (pop) begin
      shift_n   = fifo_dout;
      par_en_n  = parity_en;
      par_bit_n = (^fifo_dout) ^ parity_odd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx        <= STOP_BIT;
      tx_busy   <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      par_en_q  <= par_en_n;
      par_bit_q <= par_bit_n;
      tx        <= tx_n;
      tx_busy   <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top: frame shapes, parity, FIFO limits and reset behaviour.
module tb_uart_tx_top;

  localparam int CPB = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       tx, tx_full, tx_busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic cap[$];
  logic bcap[$];

  always #5 clk = ~clk;

  uart_tx_top #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .d_in      (d_in),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .tx        (tx),
    .tx_full   (tx_full),
    .tx_busy   (tx_busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    int low_cnt;
    reset = 1'b0;
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b expected 1", tx); end
    tests_run++;
    if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    tests_run++;
    if (tx_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", tx_full); end
    reset = 1'b1;
    low_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) low_cnt++;
    end
    tests_run++;
    if (low_cnt !== 0) begin tests_failed++; $display("FAIL idle_high: got %0d non-idle cycles expected 0", low_cnt); end
  endtask

  // Single frame: exp[i] is the i-th level sent on the line.
  task automatic test_single_frame(input logic [7:0] data, input logic pen, input logic podd,
                                   input logic [10:0] exp, input int nbits, input string name);
    int mism;
    logic got;
    cap.delete();
    bcap.delete();
    @(negedge clk);
    wr_en = 1'b1; d_in = data; parity_en = pen; parity_odd = podd;
    @(negedge clk);
    cap.push_back(tx); bcap.push_back(tx_busy);
    wr_en = 1'b0;
    @(negedge clk);
    cap.push_back(tx); bcap.push_back(tx_busy);
    parity_en = !pen; parity_odd = !podd;
    repeat (nbits * CPB + 1) begin
      @(negedge clk);
      cap.push_back(tx); bcap.push_back(tx_busy);
    end
    tests_run++;
    if ({cap[0], cap[1], cap[2]} !== 3'b110) begin
      tests_failed++;
      $display("FAIL %s_latency: got %b%b%b expected 110", name, cap[0], cap[1], cap[2]);
    end
    for (int b = 0; b < nbits; b++) begin
      mism = 0;
      got = exp[b];
      for (int s = 0; s < CPB; s++) begin
        if (cap[2 + b*CPB + s] !== exp[b]) begin mism++; got = cap[2 + b*CPB + s]; end
      end
      tests_run++;
      if (mism != 0) begin
        tests_failed++;
        $display("FAIL %s_bit%0d: got %b expected %b", name, b, got, exp[b]);
      end
    end
    tests_run++;
    if (bcap[nbits*CPB] !== 1'b1 || bcap[nbits*CPB + 1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_length: busy at end got %b%b expected 10", name, bcap[nbits*CPB], bcap[nbits*CPB + 1]);
    end
    parity_en = 1'b0;
    parity_odd = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_fifo_full();
    int mism, tail_low;
    logic [10:0] e;
    cap.delete();
    parity_en = 1'b0;
    for (int k = 0; k <= 2 + 9*70 + 70; k++) begin
      @(negedge clk);
      if (k >= 1) cap.push_back(tx);
      if (k == 8) begin
        tests_run++;
        if (tx_full !== 1'b0) begin tests_failed++; $display("FAIL full_before_9th: got %b expected 0", tx_full); end
      end
      if (k == 9) begin
        tests_run++;
        if (tx_full !== 1'b1) begin tests_failed++; $display("FAIL full_after_9th: got %b expected 1", tx_full); end
      end
      if (k <= 9) begin wr_en = 1'b1; d_in = 8'(k); end
      else wr_en = 1'b0;
    end
    for (int j = 0; j < 9; j++) begin
      e = {1'b0, 1'b1, 8'(j), 1'b0};
      mism = 0;
      for (int i = 0; i < 10*CPB; i++)
        if (cap[2 + 70*j + i] !== e[i/CPB]) mism++;
      tests_run++;
      if (mism != 0) begin
        tests_failed++;
        $display("FAIL fifo_frame%0d: got %0d wrong samples expected 0", j, mism);
      end
    end
    tail_low = 0;
    for (int i = 2 + 9*70; i < cap.size(); i++) if (cap[i] !== 1'b1) tail_low++;
    tests_run++;
    if (tail_low != 0) begin tests_failed++; $display("FAIL fifo_dropped_byte: got %0d low samples after 9 frames expected 0", tail_low); end
    tests_run++;
    if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL fifo_busy_end: got %b expected 0", tx_busy); end
  endtask

  task automatic test_reset_midframe();
    int bad;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      if (k == 20) begin
        tests_run++;
        if (tx !== 1'b0) begin tests_failed++; $display("FAIL mid_bit1: got %b expected 0", tx); end
      end
      if (k == 33) begin
        tests_run++;
        if (tx_busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy: got %b expected 1", tx_busy); end
        reset = 1'b0;
      end
      if (k == 34) begin
        tests_run++;
        if (tx !== 1'b1) begin tests_failed++; $display("FAIL rst_tx: got %b expected 1", tx); end
        tests_run++;
        if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", tx_busy); end
        tests_run++;
        if (tx_full !== 1'b0) begin tests_failed++; $display("FAIL rst_full: got %b expected 0", tx_full); end
        reset = 1'b1;
      end
      if (k == 0) begin wr_en = 1'b1; d_in = 8'h3C; end
      else if (k == 1) d_in = 8'h11;
      else if (k == 2) d_in = 8'h22;
      else wr_en = 1'b0;
    end
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL rst_no_resume: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_same_cycle();
    int mism, tail_low;
    logic [10:0] e;
    cap.delete();
    for (int k = 0; k <= 2 + 9*70 + 70; k++) begin
      @(negedge clk);
      if (k >= 1) cap.push_back(tx);
      if (k == 71) begin
        tests_run++;
        if (tx_full !== 1'b1) begin tests_failed++; $display("FAIL sc_full_before_pop: got %b expected 1", tx_full); end
      end
      if (k == 72) begin
        tests_run++;
        if (tx_full !== 1'b0) begin tests_failed++; $display("FAIL sc_full_after_pop: got %b expected 0", tx_full); end
      end
      if (k <= 8) begin wr_en = 1'b1; d_in = 8'(8'h10 + k); end
      else if (k == 71) begin wr_en = 1'b1; d_in = 8'hEE; end
      else wr_en = 1'b0;
    end
    for (int j = 0; j < 9; j++) begin
      e = {1'b0, 1'b1, 8'(8'h10 + j), 1'b0};
      mism = 0;
      for (int i = 0; i < 10*CPB; i++)
        if (cap[2 + 70*j + i] !== e[i/CPB]) mism++;
      tests_run++;
      if (mism != 0) begin
        tests_failed++;
        $display("FAIL sc_frame%0d: got %0d wrong samples expected 0", j, mism);
      end
    end
    tail_low = 0;
    for (int i = 2 + 9*70; i < cap.size(); i++) if (cap[i] !== 1'b1) tail_low++;
    tests_run++;
    if (tail_low != 0) begin tests_failed++; $display("FAIL sc_write_dropped: got %0d low samples after 9 frames expected 0", tail_low); end
  endtask

  initial begin
    test_reset();
    test_single_frame(8'hA5, 1'b1, 1'b0, 11'b10101001010, 11, "a5_even");
    test_single_frame(8'h01, 1'b1, 1'b1, 11'b10000000010, 11, "01_odd");
    test_single_frame(8'h01, 1'b1, 1'b0, 11'b11000000010, 11, "01_even");
    test_single_frame(8'h01, 1'b0, 1'b1, 11'b01000000010, 10, "01_nopar");
    test_single_frame(8'h3C, 1'b1, 1'b1, 11'b11001111000, 11, "3c_odd");
    test_fifo_full();
    repeat (5) @(negedge clk);
    test_reset_midframe();
    test_same_cycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
